// File: rtl/frame_cfg_pkg.sv
// rtl/frame_cfg_pkg.sv - shared frame geometry, RMW state encoding and FAR field layout
package frame_cfg_pkg;

  localparam int FRAME_WORDS_DEF = 101;
  localparam int PAD_WORDS_DEF   = 101;
  localparam int TIMEOUT_DEF     = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_CAPTURE,
    ST_PATCH,
    ST_WR_REQ,
    ST_WRITE,
    ST_DONE
  } rmw_state_e;

  // Frame address layout, common with the LUT-to-frame-address stage.
  typedef struct packed {
    logic [5:0] reserved;
    logic [2:0] block_type;
    logic       top;
    logic [4:0] hclk_row;
    logic [9:0] major;
    logic [6:0] minor;
  } far_t;

  function automatic logic [31:0] merge_half(input logic [31:0] word,
                                             input logic [15:0] half,
                                             input logic        msb);
    return msb ? {half, word[15:0]} : {word[31:16], half};
  endfunction

endpackage

// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - one-frame word store, single write port, combinational read
module frame_buffer
  import frame_cfg_pkg::*;
#(
  parameter int DEPTH = FRAME_WORDS_DEF,
  parameter int AW    = $clog2(FRAME_WORDS_DEF)
) (
  input  logic          Clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/frame_patch_rmw.sv
// rtl/frame_patch_rmw.sv - fetch a configuration frame, patch one LUT half-word, write it back
module frame_patch_rmw
  import frame_cfg_pkg::*;
#(
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int PAD_WORDS   = PAD_WORDS_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        far_valid,
  input  logic [31:0] far,
  input  logic [7:0]  word_offset,
  input  logic        msb_lsb,
  input  logic [15:0] patch_data,
  output logic        busy,
  output logic        rd_req,
  output logic [31:0] rd_far,
  input  logic        rd_ack,
  input  logic        rd_valid,
  input  logic [31:0] rd_data,
  output logic        wr_req,
  output logic [31:0] wr_far,
  input  logic        wr_ack,
  output logic        wr_valid,
  output logic [31:0] wr_data,
  output logic        wr_last,
  input  logic        wr_ready,
  output logic        done,
  output logic        error
);

  localparam int AW = $clog2(FRAME_WORDS);
  localparam int CW = $clog2(PAD_WORDS + FRAME_WORDS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  rmw_state_e    state_q, state_d;
  logic [31:0]   far_q, far_d;
  logic [AW-1:0] offset_q, offset_d;
  logic          msb_q, msb_d;
  logic [15:0]   patch_q, patch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          err_q, err_d;

  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [31:0]   buf_wdata;
  logic [AW-1:0] buf_raddr;
  logic [31:0]   buf_rdata;

  frame_buffer #(
    .DEPTH (FRAME_WORDS),
    .AW    (AW)
  ) u_frame_buffer (
    .Clk   (Clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (buf_wdata),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_d   = state_q;
    far_d     = far_q;
    offset_d  = offset_q;
    msb_d     = msb_q;
    patch_d   = patch_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    idx_d     = idx_q;
    err_d     = err_q;
    buf_we    = 1'b0;
    buf_waddr = '0;
    buf_wdata = '0;
    // The read port serves the patch merge in PATCH and the stream otherwise.
    buf_raddr = (state_q == ST_PATCH) ? offset_q : idx_q;

    busy     = (state_q != ST_IDLE);
    rd_req   = (state_q == ST_RD_REQ);
    wr_req   = (state_q == ST_WR_REQ);
    wr_valid = (state_q == ST_WRITE);
    wr_data  = buf_rdata;
    wr_last  = (state_q == ST_WRITE) && (idx_q == AW'(FRAME_WORDS - 1));
    done     = (state_q == ST_DONE);
    error    = (state_q == ST_DONE) && err_q;
    rd_far   = far_q;
    wr_far   = far_q;

    case (state_q)
      ST_IDLE: begin
        if (far_valid) begin
          far_d    = far;
          offset_d = word_offset[AW-1:0];
          msb_d    = msb_lsb;
          patch_d  = patch_data;
          if (32'(word_offset) >= 32'(FRAME_WORDS)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        if (rd_ack) begin
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (rd_valid) begin
          tmo_d = '0;
          cnt_d = cnt_q + CW'(1);
          // Leading pad-frame beats are counted but never stored.
          if (cnt_q >= CW'(PAD_WORDS)) begin
            buf_we    = 1'b1;
            buf_waddr = AW'(cnt_q - CW'(PAD_WORDS));
            buf_wdata = rd_data;
          end
          if (cnt_q == CW'(PAD_WORDS + FRAME_WORDS - 1)) begin
            state_d = ST_PATCH;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_PATCH: begin
        buf_we    = 1'b1;
        buf_waddr = offset_q;
        buf_wdata = merge_half(buf_rdata, patch_q, msb_q);
        state_d   = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        if (wr_ack) begin
          idx_d   = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wr_ready) begin
          if (idx_q == AW'(FRAME_WORDS - 1)) begin
            err_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      far_q    <= '0;
      offset_q <= '0;
      msb_q    <= 1'b0;
      patch_q  <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      far_q    <= far_d;
      offset_q <= offset_d;
      msb_q    <= msb_d;
      patch_q  <= patch_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
    end
  end

endmodule
